// File: rtl/wimax_pingpong_ctrl.sv
// rtl/wimax_pingpong_ctrl.sv - ping-pong bank scheduler for the WiMax block interleaver bit RAM
// Optional macro PAD_FLUSH_EN: a short block ended by s_last is zero-padded to NCBPS bits.
module wimax_pingpong_ctrl #(
    parameter int NCBPS = 192,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_data,
    output logic             m_last,
    output logic             ram_wr_en,
    output logic             ram_wr_bank,
    output logic [IDX_W-1:0] ram_wr_idx,
    output logic             ram_wr_data,
    output logic             ram_rd_en,
    output logic             ram_rd_bank,
    output logic [IDX_W-1:0] ram_rd_idx,
    input  logic             ram_rd_q,
    output logic [15:0]      blocks_done
);

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCBPS - 1);

    bank_state_t      bank_state [2];
    bank_state_t      bank_nxt   [2];
    logic             wr_bank;
    logic             rd_bank;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             pend;
    logic             pend_last;
    logic             out_valid;
    logic             out_data;
    logic             out_last;
    logic             skid_valid;
    logic             skid_data;
    logic             skid_last;
    logic [15:0]      done_cnt;
    logic             pad;
    logic             accept;
    logic             wr_fire;
    logic             rd_fire;
    logic             pop;
    logic             wr_at_last;
    logic             rd_at_last;
    logic             rd_ok;
    logic [1:0]       occ;

    assign s_ready = rst_n && !pad &&
                     (bank_state[wr_bank] == BANK_EMPTY || bank_state[wr_bank] == BANK_FILLING);
    assign accept     = s_valid && s_ready;
    assign wr_fire    = accept || pad;
    assign wr_at_last = (wr_idx == LAST_IDX);
    assign rd_at_last = (rd_idx == LAST_IDX);
    assign pop        = out_valid && m_ready;
    assign rd_ok      = (bank_state[rd_bank] == BANK_FULL) || (bank_state[rd_bank] == BANK_DRAINING);

    // Committed buffer occupancy: registered bits plus the read in flight, minus this cycle's pop.
    assign occ     = 2'(out_valid) + 2'(skid_valid) + 2'(pend) - 2'(pop);
    assign rd_fire = rd_ok && (occ < 2'd2);

    assign ram_wr_en   = wr_fire;
    assign ram_wr_bank = wr_bank;
    assign ram_wr_idx  = wr_idx;
    assign ram_wr_data = pad ? 1'b0 : s_data;
    assign ram_rd_en   = rd_fire;
    assign ram_rd_bank = rd_bank;
    assign ram_rd_idx  = rd_idx;

    assign m_valid     = out_valid;
    assign m_data      = out_data;
    assign m_last      = out_last;
    assign blocks_done = done_cnt;

`ifdef PAD_FLUSH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad <= 1'b0;
        end else if (pad && wr_at_last) begin
            pad <= 1'b0;
        end else if (accept && s_last && !wr_at_last) begin
            pad <= 1'b1;
        end
    end
`else
    logic unused_s_last;
    assign pad           = 1'b0;
    assign unused_s_last = s_last;
`endif

    // Writer and reader never own the same bank, so both updates can apply in one cycle.
    always_comb begin
        bank_nxt[0] = bank_state[0];
        bank_nxt[1] = bank_state[1];
        if (wr_fire) begin
            bank_nxt[wr_bank] = wr_at_last ? BANK_FULL : BANK_FILLING;
        end
        if (rd_fire) begin
            bank_nxt[rd_bank] = rd_at_last ? BANK_EMPTY : BANK_DRAINING;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_state[0] <= BANK_EMPTY;
            bank_state[1] <= BANK_EMPTY;
        end else begin
            bank_state[0] <= bank_nxt[0];
            bank_state[1] <= bank_nxt[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank   <= 1'b0;
            wr_idx    <= '0;
            rd_bank   <= 1'b0;
            rd_idx    <= '0;
            pend      <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_idx <= wr_at_last ? '0 : wr_idx + 1'b1;
                if (wr_at_last) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (rd_fire) begin
                rd_idx <= rd_at_last ? '0 : rd_idx + 1'b1;
                if (rd_at_last) begin
                    rd_bank <= ~rd_bank;
                end
            end
            pend      <= rd_fire;
            pend_last <= rd_fire && rd_at_last;
        end
    end

    // Output register plus one skid entry; the skid only fills while the output is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= 1'b0;
            out_last   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= 1'b0;
            skid_last  <= 1'b0;
            done_cnt   <= 16'd0;
        end else begin
            if (pop || !out_valid) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    out_last   <= skid_last;
                    skid_valid <= pend;
                    skid_data  <= pend && ram_rd_q;
                    skid_last  <= pend && pend_last;
                end else begin
                    out_valid <= pend;
                    out_data  <= pend && ram_rd_q;
                    out_last  <= pend && pend_last;
                end
            end else if (pend) begin
                skid_valid <= 1'b1;
                skid_data  <= ram_rd_q;
                skid_last  <= pend_last;
            end
            if (pop && out_last) begin
                done_cnt <= done_cnt + 16'd1;
            end
        end
    end

endmodule
